// File: rtl/signext_pkg.sv
// Shared types and helpers for the sign-extending block accumulator.
// Holds the handshake state encoding and the signed-add overflow rule.
package signext_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } signext_accum_state_t;

    // Two same-signed operands whose sum flips sign have overflowed.
    function automatic logic add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/signext.sv
// Widens an N-bit two's-complement value to M bits by replicating the sign bit.
module signext #(
    parameter int unsigned N = 3,
    parameter int unsigned M = 5
) (
    input  logic [N-1:0] x,
    output logic [M-1:0] ext
);

    assign ext = {{(M - N){x[N-1]}}, x};

endmodule

// File: rtl/signext_accum.sv
// Sums CNT sign-extended samples per block and hands out each M-bit block sum
// with a sticky signed-overflow flag over a valid/ready handshake.
module signext_accum
    import signext_pkg::*;
#(
    parameter int unsigned N   = 3,
    parameter int unsigned M   = 5,
    parameter int unsigned CNT = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_x,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_sum,
    output logic         o_ovf
);

    localparam int unsigned    CW   = $clog2(CNT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CNT - 1);

    signext_accum_state_t state, state_nxt;

    logic [M-1:0]  acc, acc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ovf, ovf_nxt;
    logic [M-1:0]  sum_nxt;
    logic          sum_ovf_nxt;
    logic          valid_nxt;
    logic [M-1:0]  ext;
    logic [M-1:0]  nxt;
    logic          add_ov;

    signext #(.N(N), .M(M)) u_signext (
        .x   (i_x),
        .ext (ext)
    );

    // Next-state, handshake and datapath decisions.
    always_comb begin
        nxt         = acc + ext;
        add_ov      = add_ovf(acc[M-1], ext[M-1], nxt[M-1]);
        state_nxt   = state;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        ovf_nxt     = ovf;
        sum_nxt     = o_sum;
        sum_ovf_nxt = o_ovf;
        valid_nxt   = o_valid;
        o_ready     = 1'b1;

        case (state)
            ACCUM: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (cnt == LAST) begin
                        sum_nxt     = nxt;
                        sum_ovf_nxt = ovf | add_ov;
                        valid_nxt   = 1'b1;
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                        ovf_nxt     = 1'b0;
                        state_nxt   = OUT;
                    end else begin
                        acc_nxt = nxt;
                        cnt_nxt = cnt + CW'(1);
                        ovf_nxt = ovf | add_ov;
                    end
                end
            end
            OUT: begin
                // Sum is held until taken; a sample arriving with the take opens the next block.
                o_ready = i_ready;
                if (i_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = ACCUM;
                    if (i_valid) begin
                        if (CNT == 1) begin
                            sum_nxt     = ext;
                            sum_ovf_nxt = 1'b0;
                            valid_nxt   = 1'b1;
                            state_nxt   = OUT;
                        end else begin
                            acc_nxt = ext;
                            cnt_nxt = CW'(1);
                            ovf_nxt = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf_nxt;
            o_valid <= valid_nxt;
            o_sum   <= sum_nxt;
            o_ovf   <= sum_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_signext_accum.sv
// Self-checking bench for signext_accum: directed scenarios plus randomized
// traffic compared against a transaction-level model of the block sum.
module tb_signext_accum;

    localparam int unsigned N   = 3;
    localparam int unsigned M   = 5;
    localparam int unsigned CNT = 8;
    localparam int          MAXV = (1 << (M - 1)) - 1;
    localparam int          MINV = -(1 << (M - 1));

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_x;
    logic         o_valid;
    logic         i_ready;
    logic [M-1:0] o_sum;
    logic         o_ovf;

    int passed;
    int total;

    // Model: signed integer running sum wrapped into the M-bit range.
    int m_acc;
    int m_cnt;
    bit m_ovf;
    bit m_pend;
    int m_psum;
    bit m_pov;

    signext_accum #(.N(N), .M(M), .CNT(CNT)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_x     (i_x),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sval(input logic [N-1:0] x);
        return int'($signed(x));
    endfunction

    task automatic model_reset();
        m_acc  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_pend = 1'b0;
        m_psum = 0;
        m_pov  = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit r, input logic [N-1:0] x);
        bit rdy;
        int s;
        rdy = !m_pend || r;
        if (m_pend && r) m_pend = 1'b0;
        if (v && rdy) begin
            s = m_acc + sval(x);
            if (s > MAXV || s < MINV) begin
                m_ovf = 1'b1;
                s = (s > MAXV) ? s - (1 << M) : s + (1 << M);
            end
            m_acc = s;
            m_cnt++;
            if (m_cnt == int'(CNT)) begin
                m_pend = 1'b1;
                m_psum = m_acc;
                m_pov  = m_ovf;
                m_acc  = 0;
                m_cnt  = 0;
                m_ovf  = 1'b0;
            end
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge.
    task automatic drive(input bit r_in, input bit v, input bit r, input logic [N-1:0] x);
        rst     = r_in;
        i_valid = v;
        i_ready = r;
        i_x     = x;
        @(posedge clk);
        if (r_in) model_reset();
        else      model_step(v, r, x);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 3'b011);
        rst = 1'b0;
        i_valid = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else passed++;
        total++; if (o_sum !== 5'b00000) $display("FAIL reset_sum got=%b exp=00000", o_sum); else passed++;
        total++; if (o_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", o_ovf); else passed++;
        total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", o_ready); else passed++;
    endtask

    task automatic test_ones();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 3'b001);
            if (i == 6) begin
                total++; if (o_valid !== 1'b0) $display("FAIL ones_early_valid got=%b exp=0", o_valid); else passed++;
            end
        end
        total++; if (o_valid !== 1'b1) $display("FAIL ones_valid got=%b exp=1", o_valid); else passed++;
        total++; if (o_sum !== 5'b01000) $display("FAIL ones_sum got=%b exp=01000", o_sum); else passed++;
        total++; if (o_ovf !== 1'b0) $display("FAIL ones_ovf got=%b exp=0", o_ovf); else passed++;
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        total++; if (o_valid !== 1'b0) $display("FAIL ones_pulse got=%b exp=0", o_valid); else passed++;
    endtask

    task automatic test_neg_ovf();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 3'b100);
        total++; if (o_valid !== 1'b1) $display("FAIL neg_valid got=%b exp=1", o_valid); else passed++;
        total++; if (o_sum !== 5'b00000) $display("FAIL neg_sum got=%b exp=00000", o_sum); else passed++;
        total++; if (o_ovf !== 1'b1) $display("FAIL neg_ovf got=%b exp=1", o_ovf); else passed++;
        drive(1'b0, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 3'b011 : 3'b111);
        total++; if (o_sum !== 5'b01000) $display("FAIL alt_sum got=%b exp=01000", o_sum); else passed++;
        total++; if (o_ovf !== 1'b0) $display("FAIL alt_ovf got=%b exp=0", o_ovf); else passed++;
        drive(1'b0, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 3'b001);
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_ready = 1'b0;
            i_x     = 3'($urandom_range(0, 7));
            #1;
            total++; if (o_ready !== 1'b0) $display("FAIL bp_ready got=%b exp=0", o_ready); else passed++;
            @(posedge clk);
            model_step(1'b1, 1'b0, i_x);
            #1;
            total++; if (o_valid !== 1'b1 || o_sum !== 5'b01000)
                $display("FAIL bp_hold got=%b/%b exp=1/01000", o_valid, o_sum); else passed++;
        end
        drive(1'b0, 1'b1, 1'b1, 3'b010);
        total++; if (o_valid !== 1'b0) $display("FAIL bp_take got=%b exp=0", o_valid); else passed++;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1, 3'b000);
        total++; if (o_valid !== 1'b1) $display("FAIL bp_next_valid got=%b exp=1", o_valid); else passed++;
        total++; if (o_sum !== 5'b00010) $display("FAIL bp_next_sum got=%b exp=00010", o_sum); else passed++;
        drive(1'b0, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic test_reset_midblock();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 3'b011);
        drive(1'b1, 1'b0, 1'b1, 3'b000);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 3'b001);
        total++; if (o_valid !== 1'b1 || o_sum !== 5'b01000)
            $display("FAIL midrst_sum got=%b/%b exp=1/01000", o_valid, o_sum); else passed++;
        drive(1'b0, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3 * int'(CNT); i++) begin
            drive(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)));
            total++; if (o_ready !== 1'b1) $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, o_ready); else passed++;
            total++; if (o_valid !== m_pend) $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, o_valid, m_pend); else passed++;
            if (m_pend) begin
                pulses++;
                total++; if (o_sum !== M'(m_psum) || o_ovf !== m_pov)
                    $display("FAIL b2b_sum cyc=%0d got=%b/%b exp=%b/%b", i, o_sum, o_ovf, M'(m_psum), m_pov); else passed++;
            end
        end
        total++; if (pulses != 3) $display("FAIL b2b_count got=%0d exp=3", pulses); else passed++;
        drive(1'b0, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic test_random();
        bit v;
        bit r;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            i_valid = v;
            i_ready = r;
            i_x     = 3'($urandom_range(0, 7));
            #1;
            total++; if (o_ready !== (!m_pend || r)) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, o_ready, !m_pend || r); else passed++;
            total++; if (o_valid !== m_pend) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, o_valid, m_pend); else passed++;
            if (m_pend) begin
                total++; if (o_sum !== M'(m_psum) || o_ovf !== m_pov)
                    $display("FAIL rnd_sum cyc=%0d got=%b/%b exp=%b/%b", i, o_sum, o_ovf, M'(m_psum), m_pov); else passed++;
            end
            @(posedge clk);
            model_step(v, r, i_x);
            #1;
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst     = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_x     = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_ones();
        test_neg_ovf();
        test_alternating();
        test_backpressure();
        test_reset_midblock();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
